// File: rtl/decomp_pkg.sv
// rtl/decomp_pkg.sv - shared types and defaults for the decompression sequencer
// Purpose: FSM state and PC-classification enums plus default parameter values.
package decomp_pkg;

   typedef enum logic {FETCH, EXPAND} seq_state_t;

   typedef enum logic [1:0] {SEQ, REPEAT, BRANCH} pc_class_t;

   localparam logic [31:0] PC_RST_DEFAULT = 32'hFFFF_FFFC;
   localparam logic [3:0]  OPCODE_DEFAULT = 4'b1111;

endpackage

// File: rtl/decomp_pc_classifier.sv
// rtl/decomp_pc_classifier.sv - classifies a CPU fetch PC against the previous one
// Purpose: combinational SEQ / REPEAT / BRANCH decision.
// Ports:
//   cpu_pc       in  WIDTH   PC of the current request
//   last_cpu_pc  in  WIDTH   PC of the last accepted request
//   pc_class     out         SEQ (last+PCADD), REPEAT (same PC) or BRANCH
module decomp_pc_classifier
   import decomp_pkg::*;
#(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] PCADD = 'h4
) (
   input  logic [WIDTH-1:0] cpu_pc,
   input  logic [WIDTH-1:0] last_cpu_pc,
   output pc_class_t        pc_class
);

   logic [WIDTH-1:0] seq_pc;

   // Sum wraps modulo 2^WIDTH, so the reset value last+PCADD lands on PC 0.
   assign seq_pc = last_cpu_pc + PCADD;

   always_comb begin
      pc_class = BRANCH;
      if (cpu_pc == seq_pc)
         pc_class = SEQ;
      else if (cpu_pc == last_cpu_pc)
         pc_class = REPEAT;
   end

endmodule

// File: rtl/decomp_sequencer.sv
// rtl/decomp_sequencer.sv - fetch sequencer for the instruction-decompression path
// Purpose: maps the CPU PC stream onto the compressed PC, expands tokens into two
// table words delivered on consecutive fetches, handles branches and table-write stalls.
// Ports:
//   clk, reset                  clock (rising) and async active-low reset
//   cpu_req, cpu_pc             CPU fetch request and program counter
//   wme                         token-table write enable, blocks fetches
//   stall                       request present but not accepted this cycle
//   mem_addr, mem_rdata         compressed-memory address / combinational read data
//   tbl_addr0/1, tbl_data0/1    token-table indexes (consecutive, wrapping) and words
//   instr_out, instr_valid      registered response, valid one cycle after acceptance
module decomp_sequencer
   import decomp_pkg::*;
#(
   parameter int                 WIDTH   = 32,
   parameter logic [WIDTH-1:0]   PCADD   = 'h4,
   parameter int                 ENC_LEN = 4,
   parameter logic [ENC_LEN-1:0] OPCODE  = OPCODE_DEFAULT,
   parameter logic [WIDTH-1:0]   PC_RST  = PC_RST_DEFAULT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cpu_req,
   input  logic [WIDTH-1:0]           cpu_pc,
   input  logic                       wme,
   output logic                       stall,
   output logic [WIDTH-1:0]           mem_addr,
   input  logic [WIDTH-1:0]           mem_rdata,
   output logic [WIDTH-ENC_LEN-1:0]   tbl_addr0,
   output logic [WIDTH-ENC_LEN-1:0]   tbl_addr1,
   input  logic [WIDTH-1:0]           tbl_data0,
   input  logic [WIDTH-1:0]           tbl_data1,
   output logic [WIDTH-1:0]           instr_out,
   output logic                       instr_valid
);

   localparam int TW = WIDTH - ENC_LEN;
   localparam logic [TW-1:0] TBL_ONE = {{(TW-1){1'b0}}, 1'b1};

   seq_state_t       state, state_d;
   pc_class_t        pc_class;
   logic [WIDTH-1:0] cpc, cpc_d;
   logic [WIDTH-1:0] last_cpu_pc, last_d;
   logic [WIDTH-1:0] second_q, second_d;
   logic [WIDTH-1:0] instr_d;
   logic             valid_d;
   logic             accept;
   logic             token;

   decomp_pc_classifier #(
      .WIDTH (WIDTH),
      .PCADD (PCADD)
   ) u_classifier (
      .cpu_pc      (cpu_pc),
      .last_cpu_pc (last_cpu_pc),
      .pc_class    (pc_class)
   );

   assign accept    = cpu_req & ~wme;
   assign stall     = cpu_req & wme;
   assign mem_addr  = (pc_class == BRANCH) ? cpu_pc : cpc;
   assign token     = (mem_rdata[WIDTH-1 -: ENC_LEN] == OPCODE);
   assign tbl_addr0 = mem_rdata[TW-1:0];
   assign tbl_addr1 = tbl_addr0 + TBL_ONE;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= FETCH;
         cpc         <= '0;
         last_cpu_pc <= PC_RST;
         second_q    <= '0;
         instr_out   <= '0;
         instr_valid <= 1'b0;
      end else begin
         state       <= state_d;
         cpc         <= cpc_d;
         last_cpu_pc <= last_d;
         second_q    <= second_d;
         instr_out   <= instr_d;
         instr_valid <= valid_d;
      end
   end

   always_comb begin
      state_d  = state;
      cpc_d    = cpc;
      last_d   = last_cpu_pc;
      second_d = second_q;
      instr_d  = instr_out;
      valid_d  = 1'b0;
      if (accept) begin
         valid_d = 1'b1;
         if (pc_class == REPEAT) begin
            // Re-issue the held response; nothing else moves.
         end else if (state == EXPAND && pc_class == SEQ) begin
            // Second half of a token: the compressed PC already points past it.
            instr_d = second_q;
            last_d  = cpu_pc;
            state_d = FETCH;
         end else begin
            // Fresh fetch; a branch out of EXPAND simply abandons second_q.
            if (token) begin
               instr_d  = tbl_data0;
               second_d = tbl_data1;
               state_d  = EXPAND;
            end else begin
               instr_d  = mem_rdata;
               state_d  = FETCH;
            end
            cpc_d  = mem_addr + PCADD;
            last_d = cpu_pc;
         end
      end
   end

endmodule

// File: tb/tb_decomp_sequencer.sv
// tb/tb_decomp_sequencer.sv - self-checking bench for decomp_sequencer
module tb_decomp_sequencer;

   logic        clk;
   logic        reset;
   logic        cpu_req;
   logic [31:0] cpu_pc;
   logic        wme;
   logic        stall;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic [27:0] tbl_addr0;
   logic [27:0] tbl_addr1;
   logic [31:0] tbl_data0;
   logic [31:0] tbl_data1;
   logic [31:0] instr_out;
   logic        instr_valid;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb[$];

   typedef struct {
      string       name;
      logic        req;
      logic [31:0] pc;
      logic        wme;
      logic        chk_addr;
      logic [31:0] exp_addr;
      logic        exp_stall;
      logic        exp_valid;
      logic [31:0] exp_instr;
   } vec_t;

   decomp_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_req     (cpu_req),
      .cpu_pc      (cpu_pc),
      .wme         (wme),
      .stall       (stall),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .tbl_addr0   (tbl_addr0),
      .tbl_addr1   (tbl_addr1),
      .tbl_data0   (tbl_data0),
      .tbl_data1   (tbl_data1),
      .instr_out   (instr_out),
      .instr_valid (instr_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      case (a)
         32'h00: return 32'h0123_4567;
         32'h04: return 32'hF000_0003;
         32'h08: return 32'h89AB_CDEF;
         32'h40: return 32'hF000_0005;
         32'h44: return 32'h1111_0044;
         32'h50: return 32'hFFFF_FFFF;
         default: return 32'h0000_0013;
      endcase
   endfunction

   function automatic logic [31:0] tbl_f(input logic [27:0] i);
      case (i)
         28'h0000000: return 32'hDDDD_0004;
         28'h0000003: return 32'hAAAA_0001;
         28'h0000004: return 32'hBBBB_0002;
         28'h0000005: return 32'h5555_0005;
         28'h0000006: return 32'h6666_0006;
         28'hFFFFFFF: return 32'hCCCC_0003;
         default:     return 32'h0;
      endcase
   endfunction

   always_comb begin
      mem_rdata = mem_f(mem_addr);
      tbl_data0 = tbl_f(tbl_addr0);
      tbl_data1 = tbl_f(tbl_addr1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      @(negedge clk);
      cpu_req = v.req;
      cpu_pc  = v.pc;
      wme     = v.wme;
      #1;
      chk({v.name, ".stall"}, {31'b0, stall}, {31'b0, v.exp_stall});
      if (v.chk_addr) chk({v.name, ".mem_addr"}, mem_addr, v.exp_addr);
      if (v.exp_valid) sb.push_back(v.exp_instr);
   endtask

   task automatic finish_cycle(input vec_t v);
      logic [31:0] e;
      @(posedge clk);
      #1;
      chk({v.name, ".valid"}, {31'b0, instr_valid}, {31'b0, v.exp_valid});
      if (instr_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.unexpected: got %08h expected no response", v.name, instr_out);
         end else begin
            e = sb.pop_front();
            chk({v.name, ".instr"}, instr_out, e);
         end
      end
   endtask

   task automatic apply(input vec_t v);
      drive(v);
      finish_cycle(v);
   endtask

   vec_t vecs[$];
   vec_t hv;

   initial begin
      cpu_req = 1'b0;
      cpu_pc  = '0;
      wme     = 1'b0;
      reset   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.valid", {31'b0, instr_valid}, 32'h0);
      chk("rst.instr", instr_out, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      //          name     req pc       wme chk addr     stall valid instr
      vecs.push_back('{"idle",  0, 32'h00, 0, 0, 32'h00, 0, 0, 32'h0});
      vecs.push_back('{"s1_pc0",1, 32'h00, 0, 1, 32'h00, 0, 1, 32'h0123_4567});
      vecs.push_back('{"s1_pc4",1, 32'h04, 0, 1, 32'h04, 0, 1, 32'hAAAA_0001});
      vecs.push_back('{"s1_pc8",1, 32'h08, 0, 0, 32'h00, 0, 1, 32'hBBBB_0002});
      vecs.push_back('{"s1_pcC",1, 32'h0C, 0, 1, 32'h08, 0, 1, 32'h89AB_CDEF});
      vecs.push_back('{"s2_br0",1, 32'h00, 0, 1, 32'h00, 0, 1, 32'h0123_4567});
      vecs.push_back('{"s2_rep",1, 32'h00, 0, 1, 32'h04, 0, 1, 32'h0123_4567});
      vecs.push_back('{"s2_pc4",1, 32'h04, 0, 1, 32'h04, 0, 1, 32'hAAAA_0001});
      vecs.push_back('{"s3_br", 1, 32'h40, 0, 1, 32'h40, 0, 1, 32'h5555_0005});
      vecs.push_back('{"s3_exp",1, 32'h44, 0, 0, 32'h00, 0, 1, 32'h6666_0006});
      vecs.push_back('{"s3_seq",1, 32'h48, 0, 1, 32'h44, 0, 1, 32'h1111_0044});
      vecs.push_back('{"s4_br0",1, 32'h00, 0, 1, 32'h00, 0, 1, 32'h0123_4567});
      vecs.push_back('{"s4_pc4",1, 32'h04, 0, 1, 32'h04, 0, 1, 32'hAAAA_0001});
      vecs.push_back('{"s4_wme",1, 32'h08, 1, 0, 32'h00, 1, 0, 32'h0});
      vecs.push_back('{"s4_wid",0, 32'h08, 1, 0, 32'h00, 0, 0, 32'h0});
      vecs.push_back('{"s4_pc8",1, 32'h08, 0, 0, 32'h00, 0, 1, 32'hBBBB_0002});

      foreach (vecs[i]) apply(vecs[i]);

      // Token index at the top of the table: second index wraps to 0.
      hv = '{"s6_wrap", 1, 32'h50, 0, 1, 32'h50, 0, 1, 32'hCCCC_0003};
      drive(hv);
      chk("s6.tbl_addr0", {4'b0, tbl_addr0}, 32'h0FFF_FFFF);
      chk("s6.tbl_addr1", {4'b0, tbl_addr1}, 32'h0000_0000);
      finish_cycle(hv);

      // Async reset while in EXPAND: outputs clear without a clock edge.
      #2;
      reset = 1'b0;
      #1;
      chk("s5.rst_valid", {31'b0, instr_valid}, 32'h0);
      chk("s5.rst_instr", instr_out, 32'h0);
      sb.delete();
      @(negedge clk);
      cpu_req = 1'b0;
      reset   = 1'b1;
      apply('{"s5_pc0", 1, 32'h00, 0, 1, 32'h00, 0, 1, 32'h0123_4567});
      apply('{"s5_pc4", 1, 32'h04, 0, 1, 32'h04, 0, 1, 32'hAAAA_0001});
      apply('{"s5_pc8", 1, 32'h08, 0, 0, 32'h00, 0, 1, 32'hBBBB_0002});
      apply('{"s5_idle",0, 32'h08, 0, 0, 32'h00, 0, 0, 32'h0});

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
